// File: rtl/wfg_wb_master_if.sv
// ----------------------------------------------------------------------------
// wfg_wb_master_if
// Purpose : bundles the request/response handshake and the Wishbone classic
//           master bus of wfg_wb_master into one interface.
// Signals : req_*  - request channel (valid/ready, we, adr, dat, sel)
//           rsp_*  - response channel (valid/ready, dat, err)
//           wbm_*  - Wishbone classic master side (cyc, stb, we, adr, dat,
//                    sel out; dat, ack in)
//           busy_o - master is not idle
// Modports: master - the bus master block (wfg_wb_master)
//           slave  - everything around it (requester, Wishbone slave)
// ----------------------------------------------------------------------------
interface wfg_wb_master_if #(
    parameter int BUSW = 32
);
    // request channel
    logic                req_valid_i;
    logic                req_ready_o;
    logic                req_we_i;
    logic [BUSW-1:0]     req_adr_i;
    logic [BUSW-1:0]     req_dat_i;
    logic [BUSW/8-1:0]   req_sel_i;

    // response channel
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [BUSW-1:0]     rsp_dat_o;
    logic                rsp_err_o;

    // Wishbone classic master
    logic                wbm_cyc_o;
    logic                wbm_stb_o;
    logic                wbm_we_o;
    logic [BUSW-1:0]     wbm_adr_o;
    logic [BUSW-1:0]     wbm_dat_o;
    logic [BUSW/8-1:0]   wbm_sel_o;
    logic [BUSW-1:0]     wbm_dat_i;
    logic                wbm_ack_i;

    logic                busy_o;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        output req_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i,
        output busy_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i,
        input  busy_o
    );
endinterface

// File: rtl/wfg_wb_master.sv
// ----------------------------------------------------------------------------
// wfg_wb_master
// Purpose : turns one valid/ready request into one Wishbone classic cycle and
//           returns the result on a valid/ready response channel. A cycle that
//           sees no ack within TIMEOUT stb cycles is terminated and reported
//           with rsp_err_o = 1.
// Params  : BUSW    - address/data width (byte selects are BUSW/8 wide)
//           TIMEOUT - max stb cycles waiting for ack, 1..255
// Ports   : wb_clk_i   - clock, rising edge
//           wb_rst_n_i - synchronous reset, active low
//           bus        - wfg_wb_master_if.master (request, response, Wishbone)
// ----------------------------------------------------------------------------
module wfg_wb_master #(
    parameter int BUSW    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    wfg_wb_master_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value seen in the last allowed stb cycle: cycles are counted
    // from 0, so the TIMEOUT-th cycle holds TIMEOUT-1.
    localparam logic [7:0] W_TO_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic                r_we;
    logic [BUSW-1:0]     r_adr;
    logic [BUSW-1:0]     r_dat;
    logic [BUSW/8-1:0]   r_sel;
    logic [BUSW-1:0]     r_rsp_dat;
    logic                r_rsp_err;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // req_ready is 1 throughout IDLE, so valid alone accepts
                    if (bus.req_valid_i) begin
                        r_we    <= bus.req_we_i;
                        r_adr   <= bus.req_adr_i;
                        r_dat   <= bus.req_dat_i;
                        r_sel   <= bus.req_sel_i;
                        r_cnt   <= '0;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    // ack is checked first so it wins over a coincident timeout
                    if (bus.wbm_ack_i) begin
                        r_rsp_err <= 1'b0;
                        r_rsp_dat <= r_we ? '0 : bus.wbm_dat_i;
                        r_state   <= RESP;
                    end else if (r_cnt == W_TO_LAST) begin
                        r_rsp_err <= 1'b1;
                        r_rsp_dat <= '0;
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    // going straight to IDLE keeps req_ready low on the
                    // handshake edge, so no request is taken in that cycle
                    if (bus.rsp_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake and bus controls are pure state decodes.
    assign bus.req_ready_o = (r_state == IDLE);
    assign bus.rsp_valid_o = (r_state == RESP);
    assign bus.wbm_cyc_o   = (r_state == BUS);
    assign bus.wbm_stb_o   = (r_state == BUS);
    assign bus.busy_o      = (r_state != IDLE);

    assign bus.wbm_we_o    = r_we;
    assign bus.wbm_adr_o   = r_adr;
    assign bus.wbm_dat_o   = r_dat;
    assign bus.wbm_sel_o   = r_sel;
    assign bus.rsp_dat_o   = r_rsp_dat;
    assign bus.rsp_err_o   = r_rsp_err;

endmodule

// File: doc/wfg_wb_master.md
WFG_WB_MASTER -- requirements
Module: wfg_wb_master

Interface
REQ-001 The module SHALL have a parameter BUSW, default 32, setting the Wishbone address and data width.
REQ-002 The module SHALL have a parameter TIMEOUT, default 255, legal range 1..255, setting the maximum number of cycles stb is held waiting for ack.
REQ-003 The module SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port wb_clk_i, in, 1: clock; all state updates on the rising edge.
REQ-005 Port wb_rst_n_i, in, 1: synchronous active-low reset.
REQ-006 Port req_valid_i, in, 1: a transfer request is present.
REQ-007 Port req_ready_o, out, 1: a request is accepted on any edge where req_valid_i and req_ready_o are both 1.
REQ-008 Port req_we_i, in, 1: 1 = write, 0 = read.
REQ-009 Port req_adr_i, in, BUSW: request address.
REQ-010 Port req_dat_i, in, BUSW: write data.
REQ-011 Port req_sel_i, in, BUSW/8: byte selects.
REQ-012 Port rsp_valid_o, out, 1: a response is present.
REQ-013 Port rsp_ready_i, in, 1: the response is consumed on any edge where rsp_valid_o and rsp_ready_i are both 1.
REQ-014 Port rsp_dat_o, out, BUSW: read data.
REQ-015 Port rsp_err_o, out, 1: the transfer timed out.
REQ-016 Ports wbm_cyc_o, wbm_stb_o and wbm_we_o, out, 1 each: Wishbone classic master controls.
REQ-017 Ports wbm_adr_o and wbm_dat_o, out, BUSW each: Wishbone address and write data.
REQ-018 Port wbm_sel_o, out, BUSW/8: Wishbone byte selects.
REQ-019 Port wbm_dat_i, in, BUSW: Wishbone read data.
REQ-020 Port wbm_ack_i, in, 1: Wishbone acknowledge.
REQ-021 Port busy_o, out, 1: 1 whenever the state is not IDLE.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, BUS and RESP; all outputs are registered or decoded from state only.
REQ-023 In IDLE, req_ready_o SHALL be 1; in every other state it SHALL be 0.
REQ-024 On acceptance in IDLE, the block SHALL latch we, adr, dat and sel into the wbm_* output registers, clear the wait counter and enter BUS.
REQ-025 wbm_cyc_o and wbm_stb_o SHALL be 1 exactly while in BUS, first visible in the cycle after acceptance.
REQ-026 wbm_adr_o, wbm_dat_o, wbm_we_o and wbm_sel_o SHALL remain stable throughout BUS.
REQ-027 In BUS, the wait counter (8 bit) SHALL increment each cycle wbm_ack_i is 0.
REQ-028 In BUS, wbm_ack_i=1 SHALL cause the next state to be RESP, with rsp_err_o set to 0.
REQ-029 On an ack, rsp_dat_o SHALL capture wbm_dat_i for a read and be set to 0 for a write.
REQ-030 In BUS, wbm_ack_i=0 with counter equal to TIMEOUT-1 SHALL cause the next state to be RESP, with rsp_err_o=1 and rsp_dat_o=0; stb is therefore high for exactly TIMEOUT cycles.
REQ-031 If ack and the timeout condition occur in the same cycle, the ack SHALL win.
REQ-032 wbm_ack_i SHALL be ignored in IDLE and RESP.
REQ-033 In RESP, rsp_valid_o SHALL be 1; rsp_dat_o and rsp_err_o SHALL be held stable until the handshake, after which the state returns to IDLE.
REQ-034 A new request SHALL NOT be accepted in the same cycle as a response handshake.
REQ-035 Minimum round trip: accept at edge 0, stb high in cycle 1, ack in cycle 1, rsp_valid in cycle 2, handshake in cycle 2, req_ready in cycle 3.

Reset
REQ-036 When wb_rst_n_i=0 at a clock edge, the block SHALL enter IDLE.
REQ-037 That reset SHALL clear wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid_o, rsp_err_o and busy_o to 0.
REQ-038 That reset SHALL clear wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_dat_o and the counter to 0.
REQ-039 That reset SHALL set req_ready_o to 1.
REQ-040 A reset during BUS SHALL drop cyc/stb in the next cycle with no response issued; a reset during RESP SHALL discard the pending response.

Verification
REQ-041 The bench SHALL cover: read of adr 0x04, slave acks in the first stb cycle with 0xDEADBEEF -> rsp_valid in cycle 2, rsp_dat=0xDEADBEEF, rsp_err=0.
REQ-042 The bench SHALL cover: write 0x12345678 to adr 0x08, sel 0xF, ack after 3 wait cycles -> stb high 4 cycles with stable adr/dat/we=1, rsp_dat=0, rsp_err=0.
REQ-043 The bench SHALL cover: TIMEOUT=255 with no ack -> stb high exactly 255 cycles, then rsp_err=1, rsp_dat=0.
REQ-044 The bench SHALL cover: ack arriving in the 255th stb cycle -> success with rsp_err=0.
REQ-045 The bench SHALL cover: rsp_ready_i held 0 for 10 cycles -> rsp_valid/rsp_dat stable, req_ready=0, a stray ack is ignored; after the handshake, req_ready=1 the next cycle.
REQ-046 The bench SHALL cover: wb_rst_n_i=0 mid-BUS -> cyc/stb=0 the next cycle, no rsp_valid, req_ready=1.
